// File: rtl/stim_pulse_sequencer.sv
// Biphasic, charge-balanced stimulation pulse-train sequencer with recording blanking.
// Optional charge-recovery phase: define STIM_CHARGE_RECOVERY_EN.
module stim_pulse_sequencer #(
    parameter int AMP_WIDTH       = 8,
    parameter int CNT_WIDTH       = 16,
    parameter int BLANK_TAIL      = 32,
    parameter int RECOVERY_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [3:0]           stim_group,
    input  logic [1:0]           group_function,
    input  logic [AMP_WIDTH-1:0] amplitude,
    input  logic                 cathodic_first,
    input  logic [CNT_WIDTH-1:0] phase_width,
    input  logic [CNT_WIDTH-1:0] gap_width,
    input  logic [CNT_WIDTH-1:0] pulse_period,
    input  logic [CNT_WIDTH-1:0] pulse_count,
    output logic                 stim_active,
    output logic                 stim_polarity,
    output logic [AMP_WIDTH-1:0] stim_amplitude,
    output logic [3:0]           stim_group_out,
    output logic                 stim_blank,
    output logic                 charge_recovery,
    output logic                 busy,
    output logic                 stim_done,
    output logic                 stim_error,
    output logic [CNT_WIDTH-1:0] pulses_sent
);

    // state    | meaning
    // IDLE     | waiting for an accepted start
    // PHASE1   | first phase driving current, polarity !cathodic_first
    // GAP      | inter-phase gap, no current
    // PHASE2   | second phase, inverted polarity
    // REST     | rest between pulses
    // RECOVER  | charge-recovery switch closed (macro builds only)
    // DONE     | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PHASE1 = 3'd1,
        S_GAP    = 3'd2,
        S_PHASE2 = 3'd3,
        S_REST   = 3'd4,
`ifdef STIM_CHARGE_RECOVERY_EN
        S_RECOVER = 3'd5,
`endif
        S_DONE   = 3'd6
    } state_t;

`ifdef STIM_CHARGE_RECOVERY_EN
    localparam state_t S_FINISH = S_RECOVER;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    localparam int                   BLANK_W  = $clog2(BLANK_TAIL + 2);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] REC_LOAD = CNT_WIDTH'(RECOVERY_CYCLES - 1);
    localparam logic [BLANK_W-1:0]   BLANK_LD = BLANK_W'(BLANK_TAIL);
    localparam logic [BLANK_W-1:0]   BLANK_1  = BLANK_W'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [AMP_WIDTH-1:0] amp_q;
    logic                 cath_q;
    logic [3:0]           group_q;
    logic [CNT_WIDTH-1:0] phase_q, gap_q, period_q, count_q;
    logic [CNT_WIDTH-1:0] pulses_q;
    logic [BLANK_W-1:0]   blank_q;
    logic                 error_q;
    logic                 accept, reject, pulse_end;
    logic                 cnt_zero, more_pulses;
    logic [CNT_WIDTH:0]   next_count;

    // A zero phase width still produces a one-cycle phase.
    function automatic logic [CNT_WIDTH-1:0] phase_load(input logic [CNT_WIDTH-1:0] w);
        return (w == '0) ? '0 : w - CNT_ONE;
    endfunction

    assign cnt_zero    = (cnt_q == '0);
    assign next_count  = {1'b0, pulses_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign more_pulses = next_count < {1'b0, count_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        reject    = 1'b0;
        pulse_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (group_function == 2'b01 && pulse_count != '0) begin
                        accept  = 1'b1;
                        state_d = S_PHASE1;
                        cnt_d   = phase_load(phase_width);
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_PHASE1: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (gap_q != '0) begin
                    state_d = S_GAP;
                    cnt_d   = gap_q - CNT_ONE;
                end else begin
                    state_d = S_PHASE2;
                    cnt_d   = phase_load(phase_q);
                end
            end
            S_GAP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_PHASE2;
                    cnt_d   = phase_load(phase_q);
                end
            end
            S_PHASE2: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    pulse_end = 1'b1;
                    if (!more_pulses) begin
                        state_d = S_FINISH;
                        cnt_d   = REC_LOAD;
                    end else if (period_q != '0) begin
                        state_d = S_REST;
                        cnt_d   = period_q - CNT_ONE;
                    end else begin
                        state_d = S_PHASE1;
                        cnt_d   = phase_load(phase_q);
                    end
                end
            end
            S_REST: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_PHASE1;
                    cnt_d   = phase_load(phase_q);
                end
            end
`ifdef STIM_CHARGE_RECOVERY_EN
            S_RECOVER: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort truncates the running pulse; it is never counted.
        if (abort && (state_q inside {S_PHASE1, S_GAP, S_PHASE2, S_REST})) begin
            state_d   = S_FINISH;
            cnt_d     = REC_LOAD;
            pulse_end = 1'b0;
        end
`ifdef STIM_CHARGE_RECOVERY_EN
        else if (abort && state_q == S_RECOVER) begin
            state_d = S_DONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            amp_q    <= '0;
            cath_q   <= 1'b0;
            group_q  <= '0;
            phase_q  <= '0;
            gap_q    <= '0;
            period_q <= '0;
            count_q  <= '0;
            pulses_q <= '0;
            blank_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= reject;
            if (accept) begin
                amp_q    <= amplitude;
                cath_q   <= cathodic_first;
                group_q  <= stim_group;
                phase_q  <= phase_width;
                gap_q    <= gap_width;
                period_q <= pulse_period;
                count_q  <= pulse_count;
                pulses_q <= '0;
            end else if (pulse_end) begin
                pulses_q <= pulses_q + CNT_ONE;
            end
            // Tail starts when DONE retires; a restart during the tail keeps blanking continuous.
            if (state_q == S_DONE) begin
                blank_q <= BLANK_LD;
            end else if (state_q == S_IDLE && blank_q != '0) begin
                blank_q <= blank_q - BLANK_1;
            end
        end
    end

    assign stim_active    = (state_q == S_PHASE1) || (state_q == S_PHASE2);
    assign stim_polarity  = (state_q == S_PHASE1) ? !cath_q :
                            (state_q == S_PHASE2) ? cath_q : 1'b0;
    assign stim_amplitude = stim_active ? amp_q : '0;
    assign stim_group_out = group_q;
    assign busy           = (state_q != S_IDLE);
    assign stim_blank     = busy || (blank_q != '0);
    assign stim_done      = (state_q == S_DONE);
    assign stim_error     = error_q;
    assign pulses_sent    = pulses_q;
`ifdef STIM_CHARGE_RECOVERY_EN
    assign charge_recovery = (state_q == S_RECOVER);
`else
    assign charge_recovery = 1'b0;
`endif

endmodule

// File: doc/stim_pulse_sequencer.md
# stim_pulse_sequencer

Generates the stimulation side of the electrode interface. It turns a single start request into a train of biphasic, charge-balanced current pulses on one electrode group. It sits beside the recording/filter path, on the output path toward the RHS headstage command builder. It drives `stim_blank` so the recording path can suppress data for the stimulated group while pulses are active.

## Interface
- `AMP_WIDTH`, 8: pulse amplitude magnitude width (RHS DAC step code).
- `CNT_WIDTH`, 16: width of all timing and pulse counters.
- `BLANK_TAIL`, 32: cycles `stim_blank` stays high after the last phase ends.
- `RECOVERY_CYCLES`, 64: charge-recovery duration. Only used with `STIM_CHARGE_RECOVERY_EN`.

Ports:
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a pulse train. Sampled every cycle.
- `abort` input 1: terminate the active train.
- `stim_group` input 4: target group, 0-9.
- `group_function` input 2: function code of `stim_group`. Only 2'b01 (stimulate) is legal.
- `amplitude` input AMP_WIDTH: phase amplitude.
- `cathodic_first` input 1: 1 = first phase cathodic.
- `phase_width` input CNT_WIDTH: cycles per phase.
- `gap_width` input CNT_WIDTH: inter-phase gap, in cycles.
- `pulse_period` input CNT_WIDTH: rest cycles between pulses.
- `pulse_count` input CNT_WIDTH: number of pulses in the train.
- `stim_active` output 1: a phase is driving current.
- `stim_polarity` output 1: 0 = cathodic, 1 = anodic. Valid only when `stim_active` is high.
- `stim_amplitude` output AMP_WIDTH: equals the latched amplitude while `stim_active` is high, otherwise 0.
- `stim_group_out` output 4: latched target group.
- `stim_blank` output 1: recording blanking request.
- `charge_recovery` output 1: recovery switch enable. Constant 0 when the macro is absent.
- `busy` output 1: high in any state other than IDLE.
- `stim_done` output 1: one-cycle pulse when a train completes or is aborted.
- `stim_error` output 1: one-cycle pulse when a start is rejected.
- `pulses_sent` output CNT_WIDTH: pulses completed in the current or last train.

## Operation
- FSM states: IDLE, PHASE1, GAP, PHASE2, REST, RECOVER (macro only), DONE.
- **IDLE.** `start` is accepted when `group_function == 2'b01`, `pulse_count != 0` and `abort == 0`.
  - On acceptance, latch all configuration inputs, clear `pulses_sent`, and go to PHASE1.
  - `start` with an illegal function or `pulse_count == 0`: pulse `stim_error` and stay in IDLE.
- Zero `phase_width` is clamped to 1 cycle. Zero `gap_width` skips GAP. Zero `pulse_period` skips REST.
- **PHASE1:** polarity = `!cathodic_first`. **PHASE2:** inverted polarity.
- At the end of PHASE2, `pulses_sent` increments.
  - If `pulses_sent + 1 < pulse_count`, go to REST (or straight to PHASE1 if REST is skipped).
  - Otherwise go to DONE (via RECOVER when enabled).
- **DONE:** pulse `stim_done` for one cycle, then return to IDLE.
- `start` while `busy` is high is ignored silently.
- `abort` in any non-IDLE state forces DONE on the next cycle. The current phase is truncated and `pulses_sent` is not incremented for the truncated pulse.
- Configuration inputs are ignored after latching.
- Counters use unsigned arithmetic. The down-counter is loaded with `width - 1` and the state exits at 0.

## Timing
- Reset values of all outputs: 0. Reset puts the FSM in IDLE and also clears the blank counter.
- If `start` is accepted at edge T, `stim_active` is high from T+1.
- PHASE1 lasts W cycles, GAP lasts G cycles, PHASE2 lasts W cycles, REST lasts P cycles.
- Per-pulse period without recovery: 2W + G + P cycles. The final pulse omits REST.
- `stim_done` is asserted the cycle after the last PHASE2 cycle (after RECOVER when enabled). `busy` drops on the same edge that `stim_done` drops.
- `stim_blank` rises with PHASE1 of the first pulse and stays high through DONE. It then stays high for BLANK_TAIL further cycles.
- A new accepted start during the tail keeps `stim_blank` high continuously.
- If `start` and `abort` arrive in the same cycle in IDLE, `abort` wins: no start and no error.
- Reset mid-train drops every output to 0 immediately (asynchronously).

## Configuration
- Macro: `STIM_CHARGE_RECOVERY_EN`.
- **Defined:** after the final PHASE2 and after an abort, the FSM enters RECOVER for RECOVERY_CYCLES cycles, with `charge_recovery` = 1 and `stim_active` = 0. DONE follows RECOVER. `stim_blank` covers RECOVER.
- **Undefined:** RECOVER does not exist and `charge_recovery` is tied to 0.

## Test plan
- **Basic train.** Inputs: W=3, G=2, P=5, count=2, cathodic_first=1, amp=8'h40.
  - `stim_active` is high for cycles 1-3 and 6-8, and again for 14-16 and 19-21.
  - Polarity is 0 then 1 within each pulse.
  - `stim_done` pulses at cycle 22, and `pulses_sent` ends at 2.
- **Rejected starts.** `group_function` = 2'b00 → `stim_error` pulses for 1 cycle with `busy` staying 0. `pulse_count` = 0 → same response.
- **Zero widths.** W=0, G=0, P=0, count=3 → six consecutive 1-cycle active phases with alternating polarity, then `stim_done`.
- **Abort.** Assert `abort` in the 2nd cycle of PHASE2 of pulse 1 → `stim_active` drops on the next edge, `stim_done` pulses, and `pulses_sent` = 0.
- **Blanking tail and restart.** Restart 10 cycles after `stim_done` with BLANK_TAIL=32 → `stim_blank` never deasserts.
- **Reset and recovery.** Assert `reset_n` low mid-REST → all outputs are 0 asynchronously and the FSM is in IDLE. With the macro defined, `charge_recovery` is high for 64 cycles before `stim_done`.
